// File: rtl/qupls_erc_sequencer.sv
// Serialises erc-flagged instructions to a single serial functional unit:
// queue them in order, wait for each to reach the ROB head, launch, wait for done, retire.
module qupls_erc_sequencer #(
    parameter int DEPTH = 4,
    parameter int RIDW  = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alloc_v,
    input  logic [RIDW-1:0]          alloc_rid,
    output logic                     alloc_rdy,
    input  logic [RIDW-1:0]          head_rid,
    input  logic                     flush,
    output logic                     go_v,
    output logic [RIDW-1:0]          go_rid,
    input  logic                     go_ack,
    input  logic                     done,
    output logic                     retire_v,
    output logic [RIDW-1:0]          retire_rid,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_HEAD,
        LAUNCH,
        EXEC,
        RETIRE
    } state_t;

    state_t          state, nstate;
    logic [RIDW-1:0] mem [DEPTH];
    logic [PW-1:0]   rptr, wptr;
    logic [CW-1:0]   cnt;
    logic [RIDW-1:0] qhead;
    logic            push, pop;

    assign alloc_rdy = (cnt != FULL);
    assign push      = alloc_v & alloc_rdy & ~flush;
    // A flush in RETIRE still shows the pulse, but the clear supersedes the pop.
    assign pop       = (state == RETIRE) & ~flush;
    assign qhead     = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rptr  <= '0;
            wptr  <= '0;
            cnt   <= '0;
        end else if (flush) begin
            state <= IDLE;
            rptr  <= '0;
            wptr  <= '0;
            cnt   <= '0;
        end else begin
            state <= nstate;
            if (push)
                wptr <= wptr + PW'(1);
            if (pop)
                rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload storage carries no reset; every read of it is gated by state.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= alloc_rid;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:      if (cnt != '0) nstate = WAIT_HEAD;
            WAIT_HEAD: if (qhead == head_rid) nstate = LAUNCH;
            LAUNCH:    if (go_ack) nstate = EXEC;
            EXEC:      if (done) nstate = RETIRE;
            RETIRE:    nstate = IDLE;
            default:   nstate = IDLE;
        endcase
    end

    // The slot under rptr cannot be rewritten while occupied, so go_rid holds through LAUNCH.
    assign go_v       = (state == LAUNCH);
    assign go_rid     = go_v ? qhead : '0;
    assign retire_v   = (state == RETIRE);
    assign retire_rid = retire_v ? qhead : '0;
    assign busy       = (state != IDLE) | (cnt != '0);
    assign count      = cnt;

endmodule

// File: tb/tb_qupls_erc_sequencer.sv
// Scoreboard bench for qupls_erc_sequencer: directed scenarios push expected
// launches/retires; a monitor pops and compares whenever the DUT presents them.
module tb_qupls_erc_sequencer;

    localparam int DEPTH = 4;
    localparam int RIDW  = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            alloc_v;
    logic [RIDW-1:0] alloc_rid;
    logic            alloc_rdy;
    logic [RIDW-1:0] head_rid;
    logic            flush;
    logic            go_v;
    logic [RIDW-1:0] go_rid;
    logic            go_ack;
    logic            done;
    logic            retire_v;
    logic [RIDW-1:0] retire_rid;
    logic            busy;
    logic [2:0]      count;

    qupls_erc_sequencer #(.DEPTH(DEPTH), .RIDW(RIDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_v(alloc_v), .alloc_rid(alloc_rid), .alloc_rdy(alloc_rdy),
        .head_rid(head_rid), .flush(flush),
        .go_v(go_v), .go_rid(go_rid), .go_ack(go_ack), .done(done),
        .retire_v(retire_v), .retire_rid(retire_rid),
        .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rid;
        int cyc;
    } go_t;

    go_t exp_go[$];
    int  exp_ret[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  n_ret = 0;
    int  fu_en = 0;
    int  done_dly = 2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Functional-unit responder: acks in the cycle go_v is seen, pulses done later.
    int  pending = 0;
    bit  acc = 0;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            go_ack  = 1'b0;
            done    = 1'b0;
            pending = 0;
            acc     = 0;
        end else begin
            done = 1'b0;
            if (pending > 0) begin
                pending--;
                if (pending == 0) done = 1'b1;
            end
            if (acc) pending = done_dly;
            acc    = go_v && (fu_en != 0);
            go_ack = acc;
        end
    end

    // Monitor
    bit go_q = 0;
    always @(posedge clk) begin
        #1;
        if (rst_n && go_v && !go_q) begin
            if (exp_go.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_go: got go_rid=%0d expected no launch", go_rid);
            end else begin
                go_t e;
                e = exp_go.pop_front();
                chk("go_rid", int'(go_rid), e.rid);
                if (e.cyc >= 0) chk("go_latency_cycle", cyc, e.cyc);
            end
        end
        go_q = go_v;
        if (rst_n && retire_v) begin
            n_ret++;
            if (exp_ret.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_retire: got retire_rid=%0d expected no retire", retire_rid);
            end else begin
                chk("retire_rid", int'(retire_rid), exp_ret.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle_timeout_busy", int'(busy), 0);
    endtask

    task automatic wait_ret(input int n);
        for (int i = 0; i < 100; i++) begin
            if (n_ret >= n) break;
            @(negedge clk);
        end
        chk("retire_timeout", int'(n_ret >= n), 1);
    endtask

    task automatic wait_go();
        for (int i = 0; i < 100; i++) begin
            if (go_v) break;
            @(negedge clk);
        end
        chk("go_timeout", int'(go_v), 1);
    endtask

    task automatic alloc(input int rid);
        alloc_v   = 1'b1;
        alloc_rid = RIDW'(rid);
        tick(1);
        alloc_v   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; alloc_v = 1'b0; alloc_rid = '0; head_rid = '0; flush = 1'b0;
        #3;
        chk("rst_count", int'(count), 0);
        chk("rst_alloc_rdy", int'(alloc_rdy), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_go_v", int'(go_v), 0);
        chk("rst_go_rid", int'(go_rid), 0);
        chk("rst_retire_v", int'(retire_v), 0);
        chk("rst_retire_rid", int'(retire_rid), 0);
        tick(2);

        // Basic flow; alloc on the first edge after reset release
        rst_n = 1'b1; fu_en = 1; done_dly = 2; head_rid = 5'd3;
        exp_go.push_back('{3, cyc + 3});
        exp_ret.push_back(3);
        alloc(3);
        chk("basic_count_after_alloc", int'(count), 1);
        wait_idle();
        chk("basic_count_end", int'(count), 0);
        chk("basic_retired", n_ret, 1);

        // Head wait
        head_rid = 5'd5;
        exp_ret.push_back(7);
        alloc(7);
        tick(10);
        chk("headwait_go_low", int'(go_v), 0);
        chk("headwait_busy", int'(busy), 1);
        head_rid = 5'd7;
        exp_go.push_back('{7, cyc + 1});
        wait_idle();

        // Full queue
        head_rid = 5'd0;
        for (int i = 1; i <= 5; i++) begin
            alloc_v = 1'b1; alloc_rid = RIDW'(i);
            tick(1);
            if (i == 4) chk("full_alloc_rdy", int'(alloc_rdy), 0);
        end
        alloc_v = 1'b0;
        chk("full_count", int'(count), 4);
        for (int r = 1; r <= 4; r++) begin
            head_rid = RIDW'(r);
            exp_go.push_back('{r, -1});
            exp_ret.push_back(r);
            wait_ret(n_ret + 1);
        end
        wait_idle();
        chk("full_count_end", int'(count), 0);

        // Flush during EXEC, with a simultaneous dropped alloc
        done_dly = 6; head_rid = 5'd10;
        exp_go.push_back('{10, cyc + 3});
        alloc(10); alloc(11); alloc(12);
        wait_go();
        tick(1);
        chk("flush_count_before", int'(count), 3);
        flush = 1'b1; alloc_v = 1'b1; alloc_rid = 5'd13;
        tick(1);
        flush = 1'b0; alloc_v = 1'b0;
        chk("flush_count", int'(count), 0);
        chk("flush_busy", int'(busy), 0);
        chk("flush_go_v", int'(go_v), 0);
        tick(10);
        chk("flush_count_later", int'(count), 0);

        // Alloc coinciding with RETIRE
        done_dly = 3; head_rid = 5'd2;
        exp_go.push_back('{2, cyc + 3});
        exp_ret.push_back(2);
        alloc(2); alloc(4);
        for (int i = 0; i < 100; i++) begin
            if (retire_v) break;
            @(negedge clk);
        end
        chk("simul_in_retire", int'(retire_v), 1);
        chk("simul_count_before", int'(count), 2);
        alloc(9);
        chk("simul_count_after", int'(count), 2);
        head_rid = 5'd4;
        exp_go.push_back('{4, -1});
        exp_ret.push_back(4);
        wait_ret(n_ret + 1);
        head_rid = 5'd9;
        exp_go.push_back('{9, -1});
        exp_ret.push_back(9);
        wait_idle();

        // Asynchronous reset mid-LAUNCH
        fu_en = 0; head_rid = 5'd20;
        exp_go.push_back('{20, cyc + 3});
        alloc(20);
        wait_go();
        #2 rst_n = 1'b0;
        #1;
        chk("areset_go_v", int'(go_v), 0);
        chk("areset_count", int'(count), 0);
        chk("areset_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);
        chk("post_reset_alloc_rdy", int'(alloc_rdy), 1);
        chk("post_reset_count", int'(count), 0);
        chk("post_reset_go_v", int'(go_v), 0);

        chk("go_expectations_left", exp_go.size(), 0);
        chk("retire_expectations_left", exp_ret.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qupls_erc_sequencer.md
QUPLS_ERC_SEQUENCER -- requirements
Module: Qupls_erc_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the pending-entry queue depth (power of two, 2..16).
REQ-002 Parameter RIDW, default 5, SHALL set the ROB index width.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset. The ports are:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- alloc_v  in  1  decoder reports an erc-flagged instruction.
- alloc_rid  in  RIDW  ROB index of that instruction.
- alloc_rdy  out  1  queue not full.
- head_rid  in  RIDW  ROB index of the oldest uncommitted instruction.
- flush  in  1  pipeline flush.
- go_v  out  1  launch request to the serial functional unit.
- go_rid  out  RIDW  ROB index being launched.
- go_ack  in  1  functional unit accepts the launch.
- done  in  1  functional unit has finished the launched instruction.
- retire_v  out  1  one-cycle retire pulse.
- retire_rid  out  RIDW  ROB index being retired.
- busy  out  1  state is not IDLE, or the queue is non-empty.
- count  out  $clog2(DEPTH)+1  number of occupied queue entries.

Function
REQ-004 Queue: circular FIFO, DEPTH entries, read and write pointers wrap modulo DEPTH; full when count==DEPTH, empty when count==0.
REQ-005 alloc_rdy SHALL equal (count!=DEPTH); it is combinational from registered count.
REQ-006 Write: alloc_v & alloc_rdy & !flush SHALL store alloc_rid at the write pointer and advance the pointer.
REQ-007 alloc_v while full SHALL be ignored, with no state change and no overflow.
REQ-008 FSM states are IDLE, WAIT_HEAD, LAUNCH, EXEC and RETIRE, all registered.
REQ-009 IDLE -> WAIT_HEAD when count!=0.
REQ-010 WAIT_HEAD -> LAUNCH when queue-head rid == head_rid; otherwise it stays.
REQ-011 LAUNCH: go_v=1 and go_rid=queue-head rid. go_v and go_rid SHALL be held stable until go_ack; on go_ack -> EXEC.
REQ-012 EXEC: go_v=0; on done -> RETIRE. done in any other state SHALL be ignored.
REQ-013 RETIRE: retire_v=1 and retire_rid=queue-head rid for exactly one cycle; the queue SHALL pop (read pointer +1, count -1), then -> IDLE.
REQ-014 A simultaneous write and pop SHALL leave count unchanged and apply both pointer updates.
REQ-015 Minimum latency: alloc accepted in cycle N with a matching head_rid SHALL give go_v high in cycle N+3 (N+1 IDLE sees count, N+2 WAIT_HEAD compares, N+3 LAUNCH).
REQ-016 go_ack in the same cycle go_v first rises SHALL be honoured, so EXEC is entered the next cycle.
REQ-017 Flush: in any state, flush SHALL, on the next edge, force IDLE, clear both pointers and count, and suppress retire_v; an alloc in the same cycle is dropped (flush wins).
REQ-018 Flush asserted during RETIRE SHALL still allow that cycle's retire_v pulse, because the pulse is already registered state; the pop is superseded by the clear.
REQ-019 Only one instruction SHALL be in LAUNCH/EXEC/RETIRE at a time; strict in-order processing by queue order.
REQ-020 busy SHALL be (state!=IDLE) | (count!=0).

Reset
REQ-021 On rst_n low, immediately and asynchronously: state=IDLE, pointers=0, count=0, go_v=0, go_rid=0, retire_v=0, retire_rid=0, busy=0, alloc_rdy=1.
REQ-022 Reset asserted mid-operation (any state) SHALL abandon the in-flight instruction with no retire_v.
REQ-023 The first alloc SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-024 Basic flow: alloc rid=3 with head_rid=3, go_ack at first go_v, done 2 cycles later -> go_v in cycle 3 with go_rid=3, then a single retire_v with retire_rid=3, count returns to 0.
REQ-025 Head wait: alloc rid=7 with head_rid=5 for 10 cycles, then 7 -> go_v stays 0 until the cycle after head_rid=7 is seen in WAIT_HEAD, then go_rid=7.
REQ-026 Full: 5 allocs rids 1..5 at DEPTH=4 with head_rid held at 0 -> alloc_rdy=0 after the 4th, rid 5 dropped, count=4; then retiring 1..4 in order yields no rid 5.
REQ-027 Flush in EXEC: flush with count=3 -> next cycle state IDLE, count=0, busy=0, and a subsequent done produces no retire_v.
REQ-028 Simultaneous ops: alloc rid=9 in the same cycle as RETIRE of rid=2 with count=2 -> count stays 2, and the order is next-head then 9.
REQ-029 Async reset: rst_n pulled low mid-LAUNCH between clock edges -> go_v=0 immediately, and after release alloc_rdy=1 and count=0.
